// File: rtl/mm2s_sts_rx.sv
// mm2s_sts_rx: closes out MM2S read commands from the DataMover status stream.
// Tracks commands in flight, checks each status beat, pulses a done per good
// completion and latches the first error cause until err_clr.
// Optional watchdog: define MM2S_STS_TIMEOUT_EN to flag a stalled BUSY period
// (error code 7) after TIMEOUT_CYCLES cycles without a status beat.
module mm2s_sts_rx #(
  parameter logic [3:0]  EXP_TAG         = 4'hA,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cmd_fire,
  input  logic       err_clr,
  input  logic       s_axis_mm2s_sts_tvalid,
  output logic       s_axis_mm2s_sts_tready,
  input  logic [7:0] s_axis_mm2s_sts_tdata,
  input  logic       s_axis_mm2s_sts_tkeep,
  input  logic       s_axis_mm2s_sts_tlast,
  output logic       axi2uip_rd_done,
  output logic       axi2uip_rd_err,
  output logic [3:0] err_code,
  output logic [3:0] outstanding,
  output logic       cmd_block
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

  state_t     state, state_nxt;
  logic       accept;
  logic [3:0] cnt_nxt;
  logic [3:0] beat_err;
  logic [3:0] cnt_err;
  logic [3:0] to_err;
  logic [3:0] err_cause;
  logic       err_now;
  logic       done_nxt;

  // Single-beat status: keep and last carry no information here.
  logic unused_sts_sideband;
  assign unused_sts_sideband = s_axis_mm2s_sts_tkeep & s_axis_mm2s_sts_tlast;

  assign accept    = s_axis_mm2s_sts_tvalid & s_axis_mm2s_sts_tready;
  assign cmd_block = (outstanding == MAX_CNT);

`ifdef MM2S_STS_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd;

  // Watchdog fires on the TIMEOUT_CYCLES-th consecutive BUSY cycle without a beat.
  assign to_err = (state == ST_BUSY && !accept && wd == WD_W'(TIMEOUT_CYCLES - 1)) ? 4'd7 : 4'd0;

  // Watchdog counter: cleared in IDLE, on accept and on expiry; frozen in ERROR.
  always_ff @(posedge clk) begin
    if (!rstn || state == ST_IDLE) begin
      wd <= '0;
    end else if (state == ST_BUSY) begin
      if (accept || to_err != 4'd0) wd <= '0;
      else                          wd <= wd + 1'b1;
    end
  end
`else
  localparam int unsigned UNUSED_TIMEOUT = TIMEOUT_CYCLES;
  assign to_err = 4'd0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: errors win, ERROR is sticky until err_clr.
  always_comb begin
    state_nxt = state;
    if (err_now)
      state_nxt = ST_ERROR;
    else if (state == ST_ERROR && !err_clr)
      state_nxt = ST_ERROR;
    else
      state_nxt = (cnt_nxt != 4'd0) ? ST_BUSY : ST_IDLE;
  end

  // Beat check, counter update and error cause selection.
  // A malformed beat outranks a counter fault, which outranks the watchdog.
  always_comb begin
    beat_err = 4'd0;
    if (accept) begin
      if      (s_axis_mm2s_sts_tdata[4])                 beat_err = 4'd3;
      else if (s_axis_mm2s_sts_tdata[5])                 beat_err = 4'd2;
      else if (s_axis_mm2s_sts_tdata[6])                 beat_err = 4'd1;
      else if (s_axis_mm2s_sts_tdata[3:0] != EXP_TAG)    beat_err = 4'd4;
      else if (!s_axis_mm2s_sts_tdata[7])                beat_err = 4'd8;
    end

    cnt_nxt = outstanding;
    cnt_err = 4'd0;
    if (cmd_fire && !accept) begin
      if (outstanding == MAX_CNT) cnt_err = 4'd6;
      else                        cnt_nxt = outstanding + 4'd1;
    end else if (accept && !cmd_fire) begin
      if (outstanding == 4'd0) cnt_err = 4'd5;
      else                     cnt_nxt = outstanding - 4'd1;
    end

    if      (beat_err != 4'd0) err_cause = beat_err;
    else if (cnt_err  != 4'd0) err_cause = cnt_err;
    else                       err_cause = to_err;

    err_now  = (err_cause != 4'd0);
    done_nxt = accept && (beat_err == 4'd0) && (cnt_err == 4'd0) && (state != ST_ERROR);
  end

  // Registered outputs; first error latched unless err_clr opens the latch.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s_axis_mm2s_sts_tready <= 1'b0;
      axi2uip_rd_done        <= 1'b0;
      axi2uip_rd_err         <= 1'b0;
      err_code               <= 4'd0;
      outstanding            <= 4'd0;
    end else begin
      s_axis_mm2s_sts_tready <= 1'b1;
      axi2uip_rd_done        <= done_nxt;
      axi2uip_rd_err         <= (state_nxt == ST_ERROR);
      outstanding            <= cnt_nxt;
      if (err_now && (state != ST_ERROR || err_clr))
        err_code <= err_cause;
      else if (err_clr)
        err_code <= 4'd0;
    end
  end

endmodule

// File: tb/tb_mm2s_sts_rx.sv
// Directed bench for mm2s_sts_rx with hand-computed expectations.
module tb_mm2s_sts_rx;

  logic       clk = 1'b0;
  logic       rstn;
  logic       cmd_fire;
  logic       err_clr;
  logic       tvalid;
  logic       tready;
  logic [7:0] tdata;
  logic       tkeep;
  logic       tlast;
  logic       rd_done;
  logic       rd_err;
  logic [3:0] err_code;
  logic [3:0] outstanding;
  logic       cmd_block;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mm2s_sts_rx #(
    .EXP_TAG(4'hA),
    .MAX_OUTSTANDING(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .cmd_fire(cmd_fire),
    .err_clr(err_clr),
    .s_axis_mm2s_sts_tvalid(tvalid),
    .s_axis_mm2s_sts_tready(tready),
    .s_axis_mm2s_sts_tdata(tdata),
    .s_axis_mm2s_sts_tkeep(tkeep),
    .s_axis_mm2s_sts_tlast(tlast),
    .axi2uip_rd_done(rd_done),
    .axi2uip_rd_err(rd_err),
    .err_code(err_code),
    .outstanding(outstanding),
    .cmd_block(cmd_block)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_fire = 1'b0;
    err_clr  = 1'b0;
    tvalid   = 1'b0;
    tdata    = 8'h00;
  endtask

  task automatic beat(input logic [7:0] d);
    tvalid = 1'b1;
    tdata  = d;
    tick();
    idle_inputs();
  endtask

  task automatic fire();
    cmd_fire = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic clear();
    err_clr = 1'b1;
    tick();
    idle_inputs();
  endtask

  initial begin
    tkeep = 1'b1;
    tlast = 1'b1;
    idle_inputs();
    rstn = 1'b0;
    tick();
    tick();
    check("rst_tready", {7'd0, tready}, 8'd0);
    check("rst_done", {7'd0, rd_done}, 8'd0);
    check("rst_err", {7'd0, rd_err}, 8'd0);
    check("rst_code", {4'd0, err_code}, 8'd0);
    check("rst_outs", {4'd0, outstanding}, 8'd0);
    check("rst_block", {7'd0, cmd_block}, 8'd0);
    rstn = 1'b1;
    tick();
    check("tready_up", {7'd0, tready}, 8'd1);

    // Single good command.
    fire();
    check("one_outs", {4'd0, outstanding}, 8'd1);
    beat(8'h8A);
    check("one_done", {7'd0, rd_done}, 8'd1);
    check("one_outs0", {4'd0, outstanding}, 8'd0);
    check("one_code", {4'd0, err_code}, 8'd0);
    tick();
    check("one_done_off", {7'd0, rd_done}, 8'd0);

    // Fill to MAX, then overflow.
    for (int i = 1; i <= 4; i++) begin
      fire();
      check("fill_outs", {4'd0, outstanding}, 8'(i));
    end
    check("fill_block", {7'd0, cmd_block}, 8'd1);
    fire();
    check("ovf_code", {4'd0, err_code}, 8'd6);
    check("ovf_err", {7'd0, rd_err}, 8'd1);
    check("ovf_outs", {4'd0, outstanding}, 8'd4);
    clear();
    check("ovf_clr_err", {7'd0, rd_err}, 8'd0);
    check("ovf_clr_code", {4'd0, err_code}, 8'd0);

    // SLVERR, then a later DECERR that must not overwrite the first cause.
    beat(8'hCA);
    check("slv_code", {4'd0, err_code}, 8'd1);
    check("slv_done", {7'd0, rd_done}, 8'd0);
    check("slv_outs", {4'd0, outstanding}, 8'd3);
    beat(8'h2A);
    check("dec_keep", {4'd0, err_code}, 8'd1);
    check("dec_outs", {4'd0, outstanding}, 8'd2);
    check("dec_err", {7'd0, rd_err}, 8'd1);
    clear();
    check("slv_clr_err", {7'd0, rd_err}, 8'd0);
    check("slv_clr_code", {4'd0, err_code}, 8'd0);
    beat(8'h8A);
    check("drain_done1", {7'd0, rd_done}, 8'd1);
    beat(8'h8A);
    check("drain_done2", {7'd0, rd_done}, 8'd1);
    check("drain_outs", {4'd0, outstanding}, 8'd0);

    // Bad tag.
    fire();
    beat(8'h85);
    check("tag_code", {4'd0, err_code}, 8'd4);
    check("tag_outs", {4'd0, outstanding}, 8'd0);
    clear();

    // Beat with nothing outstanding.
    beat(8'h8A);
    check("unf_code", {4'd0, err_code}, 8'd5);
    check("unf_done", {7'd0, rd_done}, 8'd0);
    check("unf_outs", {4'd0, outstanding}, 8'd0);
    clear();

    // Fire and accept in the same cycle with count 2.
    fire();
    fire();
    cmd_fire = 1'b1;
    tvalid   = 1'b1;
    tdata    = 8'h8A;
    tick();
    idle_inputs();
    check("both_outs", {4'd0, outstanding}, 8'd2);
    check("both_done", {7'd0, rd_done}, 8'd1);

    // Priority: INTERR beats everything, DECERR beats bad tag.
    beat(8'hFA);
    check("prio_int", {4'd0, err_code}, 8'd3);
    clear();
    beat(8'h25);
    check("prio_dec", {4'd0, err_code}, 8'd2);
    check("prio_outs", {4'd0, outstanding}, 8'd0);

    // Commands still counted in ERROR; err_clr with a new error captures it.
    fire();
    fire();
    check("err_fire_outs", {4'd0, outstanding}, 8'd2);
    err_clr = 1'b1;
    tvalid  = 1'b1;
    tdata   = 8'hCA;
    tick();
    idle_inputs();
    check("clr_new_code", {4'd0, err_code}, 8'd1);
    check("clr_new_err", {7'd0, rd_err}, 8'd1);
    check("clr_new_outs", {4'd0, outstanding}, 8'd1);
    clear();
    beat(8'h8A);
    check("post_clr_done", {7'd0, rd_done}, 8'd1);

    // Reset mid-operation discards in-flight commands.
    fire();
    fire();
    rstn = 1'b0;
    tick();
    check("mid_rst_outs", {4'd0, outstanding}, 8'd0);
    check("mid_rst_tready", {7'd0, tready}, 8'd0);
    rstn = 1'b1;
    tick();
    beat(8'h8A);
    check("mid_rst_done", {7'd0, rd_done}, 8'd0);
    check("mid_rst_code", {4'd0, err_code}, 8'd5);
    clear();

    // Watchdog.
    fire();
`ifdef MM2S_STS_TIMEOUT_EN
    for (int i = 0; i < 15; i++) tick();
    check("wd_early", {4'd0, err_code}, 8'd0);
    tick();
    check("wd_code", {4'd0, err_code}, 8'd7);
    check("wd_err", {7'd0, rd_err}, 8'd1);
`else
    for (int i = 0; i < 40; i++) tick();
    check("wd_none_code", {4'd0, err_code}, 8'd0);
    check("wd_none_err", {7'd0, rd_err}, 8'd0);
    check("wd_none_outs", {4'd0, outstanding}, 8'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
